// File: rtl/adder_seq_pkg.sv
// Shared types and default constants for the adder operand sequencer.
//  - seq_state_t : sequencer FSM state, encoding is visible on the State LEDs.
//  - DEF_*       : default parameter values for the board build.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_Y = 2'd1,
        ADD    = 2'd2,
        SHOW   = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_WIDTH           = 32'd4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd250000;
    localparam int unsigned DEF_DB_CNT_W        = 32'd18;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-sample debouncer and
// rising-edge pulse generator.
//  clk_i    in   system clock
//  rst_ni   in   asynchronous active-low reset (debounced level clears to released)
//  btn_i    in   raw button, active-high, asynchronous to clk_i
//  pulse_o  out  registered 1-cycle pulse on each accepted press
// The debounced level only flips after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from it; any sample equal to the current level restarts
// the count, so bounce shorter than DEBOUNCE_CYCLES never gets through.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd250000,
    parameter int unsigned DB_CNT_W        = 32'd18
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic [1:0]          sync_q;
    logic                sync_s;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;
    logic                db_q;
    logic                db_d;
    logic                pulse_q;
    logic                pulse_d;

    assign sync_s  = sync_q[1];
    assign pulse_o = pulse_q;

    // Two-stage synchronizer for the raw button.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Stable counter, debounced level and rising-edge detection.
    always_comb begin
        cnt_d   = cnt_q;
        db_d    = db_q;
        if (sync_s == db_q) begin
            cnt_d = {DB_CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = {DB_CNT_W{1'b0}};
            db_d  = sync_s;
        end else begin
            cnt_d = cnt_q + {{(DB_CNT_W-1){1'b0}}, 1'b1};
        end
        pulse_d = db_d & ~db_q;
    end

    // Debouncer state and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= {DB_CNT_W{1'b0}};
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Sequences an external four-bit adder from one shared switch bank.
// Next captures X, then Y plus carry-in; the adder output is sampled in the
// single-cycle ADD state and held for display in SHOW. Clr returns to LOAD_X
// and clears all captured data, and wins over a simultaneous Next.
//  Clk          in   system clock
//  Reset_n      in   async active-low reset (asserts immediately, releases on Clk)
//  Sw           in   raw operand switches
//  BtnNext      in   raw advance button
//  BtnClr       in   raw clear button
//  BtnCin       in   raw carry button, Cin = ~BtnCin
//  Sum, Cout    in   external adder result
//  InputX/InputY/Cin  out  registered adder operands
//  Result       out  {Cout,Sum} captured in ADD
//  ResultValid  out  high while in SHOW
//  State        out  current FSM state
// Build option SEQ_ACCUM_EN: Next in SHOW loads InputX with the low bits of
// Result and goes straight to LOAD_Y (running sum).
module adder_operand_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DB_CNT_W        = DEF_DB_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Sw,
    input  logic             BtnNext,
    input  logic             BtnClr,
    input  logic             BtnCin,
    input  logic [WIDTH-1:0] Sum,
    input  logic             Cout,
    output logic [WIDTH-1:0] InputX,
    output logic [WIDTH-1:0] InputY,
    output logic             Cin,
    output logic [WIDTH:0]   Result,
    output logic             ResultValid,
    output logic [1:0]       State
);

    logic [1:0]       rst_sync_q;
    logic             rst_n_s;
    logic [WIDTH-1:0] sw_meta_q;
    logic [WIDTH-1:0] sw_sync_q;
    logic             cin_meta_q;
    logic             cin_sync_q;
    logic             next_p_s;
    logic             clr_p_s;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             cin_q;
    logic             cin_d;
    logic [WIDTH:0]   res_q;
    logic [WIDTH:0]   res_d;
    logic             rv_q;
    logic             rv_d;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    // Synchronizers for the switch bank and the undebounced carry button.
    always_ff @(posedge Clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sw_meta_q  <= {WIDTH{1'b0}};
            sw_sync_q  <= {WIDTH{1'b0}};
            cin_meta_q <= 1'b0;
            cin_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= Sw;
            sw_sync_q  <= sw_meta_q;
            cin_meta_q <= BtnCin;
            cin_sync_q <= cin_meta_q;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_CNT_W        (DB_CNT_W)
    ) u_db_next (
        .clk_i   (Clk),
        .rst_ni  (rst_n_s),
        .btn_i   (BtnNext),
        .pulse_o (next_p_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_CNT_W        (DB_CNT_W)
    ) u_db_clr (
        .clk_i   (Clk),
        .rst_ni  (rst_n_s),
        .btn_i   (BtnClr),
        .pulse_o (clr_p_s)
    );

    // Next-state and operand/result capture logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cin_d   = cin_q;
        res_d   = res_q;
        if (clr_p_s) begin
            state_d = LOAD_X;
            x_d     = {WIDTH{1'b0}};
            y_d     = {WIDTH{1'b0}};
            cin_d   = 1'b0;
            res_d   = {(WIDTH+1){1'b0}};
        end else begin
            case (state_q)
                LOAD_X: begin
                    if (next_p_s) begin
                        x_d     = sw_sync_q;
                        state_d = LOAD_Y;
                    end else begin
                        state_d = LOAD_X;
                    end
                end
                LOAD_Y: begin
                    if (next_p_s) begin
                        y_d     = sw_sync_q;
                        cin_d   = ~cin_sync_q;
                        state_d = ADD;
                    end else begin
                        state_d = LOAD_Y;
                    end
                end
                ADD: begin
                    // Operands have been stable on the adder since leaving LOAD_Y.
                    res_d   = {Cout, Sum};
                    state_d = SHOW;
                end
                SHOW: begin
                    if (next_p_s) begin
`ifdef SEQ_ACCUM_EN
                        x_d     = res_q[WIDTH-1:0];
                        state_d = LOAD_Y;
`else
                        state_d = LOAD_X;
`endif
                    end else begin
                        state_d = SHOW;
                    end
                end
                default: begin
                    state_d = LOAD_X;
                end
            endcase
        end
        rv_d = (state_d == SHOW);
    end

    // FSM state, operand and result registers.
    always_ff @(posedge Clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= LOAD_X;
            x_q     <= {WIDTH{1'b0}};
            y_q     <= {WIDTH{1'b0}};
            cin_q   <= 1'b0;
            res_q   <= {(WIDTH+1){1'b0}};
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

    assign InputX      = x_q;
    assign InputY      = y_q;
    assign Cin         = cin_q;
    assign Result      = res_q;
    assign ResultValid = rv_q;
    assign State       = state_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;

    localparam int unsigned W = 4;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [W-1:0] Sw;
    logic         BtnNext;
    logic         BtnClr;
    logic         BtnCin;
    logic [W-1:0] Sum;
    logic         Cout;
    logic [W-1:0] InputX;
    logic [W-1:0] InputY;
    logic         Cin;
    logic [W:0]   Result;
    logic         ResultValid;
    logic [1:0]   State;
    logic [W:0]   add_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       btncin;
        logic [4:0] res;
    } vec_t;

    vec_t vecs[7];

    always #5 Clk = ~Clk;

    // External adder model.
    assign add_s       = {1'b0, InputX} + {1'b0, InputY} + {4'b0000, Cin};
    assign {Cout, Sum} = add_s;

    adder_operand_sequencer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4),
        .DB_CNT_W        (3)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Sw          (Sw),
        .BtnNext     (BtnNext),
        .BtnClr      (BtnClr),
        .BtnCin      (BtnCin),
        .Sum         (Sum),
        .Cout        (Cout),
        .InputX      (InputX),
        .InputY      (InputY),
        .Cin         (Cin),
        .Result      (Result),
        .ResultValid (ResultValid),
        .State       (State)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_next();
        BtnNext = 1'b1;
        idle(10);
        BtnNext = 1'b0;
        idle(10);
    endtask

    task automatic press_clr();
        BtnClr = 1'b1;
        idle(10);
        BtnClr = 1'b0;
        idle(10);
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n = 0;
        while (State !== s && n < 40) begin
            tick();
            n++;
        end
        chk(name, {30'd0, State}, {30'd0, s});
    endtask

    // Capture Y, then check ADD lasts one cycle and SHOW follows with the result.
    task automatic run_add(input logic [3:0] y, input logic c, input logic [4:0] exp_res);
        Sw      = y;
        BtnCin  = c;
        BtnNext = 1'b1;
        wait_state(2'd2, "reach_add");
        chk("rv_in_add", {31'd0, ResultValid}, 32'd0);
        tick();
        chk("state_show", {30'd0, State}, 32'd3);
        chk("rv_in_show", {31'd0, ResultValid}, 32'd1);
        chk("result", {27'd0, Result}, {27'd0, exp_res});
        BtnNext = 1'b0;
        idle(10);
        chk("result_held", {27'd0, Result}, {27'd0, exp_res});
        chk("state_held", {30'd0, State}, 32'd3);
    endtask

    initial begin
        int changes;
        logic [1:0] prev;

        vecs[0] = '{4'h3, 4'h5, 1'b0, 5'h09};
        vecs[1] = '{4'hF, 4'h1, 1'b1, 5'h10};
        vecs[2] = '{4'hF, 4'h1, 1'b0, 5'h11};
        vecs[3] = '{4'h0, 4'h0, 1'b1, 5'h00};
        vecs[4] = '{4'hA, 4'h7, 1'b0, 5'h12};
        vecs[5] = '{4'h8, 4'h8, 1'b1, 5'h10};
        vecs[6] = '{4'hF, 4'hF, 1'b0, 5'h1F};

        Reset_n = 1'b0;
        Sw      = 4'h0;
        BtnNext = 1'b0;
        BtnClr  = 1'b0;
        BtnCin  = 1'b0;
        idle(3);
        Reset_n = 1'b1;
        idle(5);
        chk("rst_state", {30'd0, State}, 32'd0);
        chk("rst_x", {28'd0, InputX}, 32'd0);
        chk("rst_result", {27'd0, Result}, 32'd0);
        chk("rst_rv", {31'd0, ResultValid}, 32'd0);

        // Table-driven operand/result vectors.
        for (int i = 0; i < 7; i++) begin
            press_clr();
            chk("clr_state", {30'd0, State}, 32'd0);
            chk("clr_x", {28'd0, InputX}, 32'd0);
            chk("clr_result", {27'd0, Result}, 32'd0);
            Sw = vecs[i].x;
            press_next();
            chk("x_state", {30'd0, State}, 32'd1);
            chk("x_capture", {28'd0, InputX}, {28'd0, vecs[i].x});
            run_add(vecs[i].y, vecs[i].btncin, vecs[i].res);
            chk("y_capture", {28'd0, InputY}, {28'd0, vecs[i].y});
            chk("cin_capture", {31'd0, Cin}, {31'd0, ~vecs[i].btncin});
        end

        // Reset in the middle of ADD clears everything without a clock edge.
        press_clr();
        Sw = 4'h6;
        press_next();
        Sw      = 4'h9;
        BtnCin  = 1'b0;
        BtnNext = 1'b1;
        wait_state(2'd2, "mid_add_reach");
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_state", {30'd0, State}, 32'd0);
        chk("async_x", {28'd0, InputX}, 32'd0);
        chk("async_y", {28'd0, InputY}, 32'd0);
        chk("async_cin", {31'd0, Cin}, 32'd0);
        chk("async_result", {27'd0, Result}, 32'd0);
        chk("async_rv", {31'd0, ResultValid}, 32'd0);
        BtnNext = 1'b0;
        idle(2);
        Reset_n = 1'b1;
        idle(10);
        chk("post_rst_state", {30'd0, State}, 32'd0);

        // Bouncing Next followed by a steady press advances exactly once.
        Sw      = 4'h6;
        changes = 0;
        prev    = State;
        for (int k = 0; k < 10; k++) begin
            BtnNext = ~BtnNext;
            for (int j = 0; j < 2; j++) begin
                tick();
                if (State !== prev) changes++;
                prev = State;
            end
        end
        BtnNext = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j == 10) BtnNext = 1'b0;
            tick();
            if (State !== prev) changes++;
            prev = State;
        end
        chk("bounce_advances", changes, 32'd1);
        chk("bounce_state", {30'd0, State}, 32'd1);
        chk("bounce_x", {28'd0, InputX}, 32'd6);

        // Clr and Next together in LOAD_Y: clear wins.
        BtnClr  = 1'b1;
        BtnNext = 1'b1;
        idle(10);
        BtnClr  = 1'b0;
        BtnNext = 1'b0;
        idle(10);
        chk("clr_prio_state", {30'd0, State}, 32'd0);
        chk("clr_prio_x", {28'd0, InputX}, 32'd0);

        // Next from SHOW.
        Sw = 4'h3;
        press_next();
        run_add(4'h5, 1'b1, 5'h08);
        press_next();
`ifdef SEQ_ACCUM_EN
        chk("accum_state", {30'd0, State}, 32'd1);
        chk("accum_x", {28'd0, InputX}, 32'd8);
        run_add(4'h2, 1'b0, 5'h0B);
        chk("accum_y", {28'd0, InputY}, 32'd2);
`else
        chk("show_next_state", {30'd0, State}, 32'd0);
        chk("show_next_x_held", {28'd0, InputX}, 32'd3);
        chk("show_next_result_held", {27'd0, Result}, 32'h08);
        chk("show_next_rv", {31'd0, ResultValid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
